bmem_arbiter: RTL

- Parametrised N-requester line-burst arbiter onto the single shared bmem burst port. Generalises today's fixed two-core (ooo + pipeline, imem + dmem) sharing scheme.
- Sits between per-core cache miss ports and fpga_mem_controller.
- Serialises line reads and writebacks with round-robin or fixed-priority selection, assembles read bursts, and routes each completed line back to its owner.

---
 rtl/bmem_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/bmem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bmem_pkg.sv
// Shared types and width helpers for the bmem line-burst arbiter.
package bmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_BEAT = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_RESP    = 3'd4
    } arb_state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_BEAT_W    = 64;
    localparam int DEF_BURST_LEN = 4;

    function automatic int line_width(input int beat_w, input int burst_len);
        return beat_w * burst_len;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection (round-robin or fixed priority) with a
// registered next-priority pointer that advances only on an accepted grant.
module rr_arbiter
    import bmem_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ARB_MODE = ARB_RR,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_en,
    output logic               grant_any,
    output logic [PTR_W-1:0]   grant_idx
);

    // ptr is the index with highest priority next time, i.e. last owner + 1.
    logic [PTR_W-1:0] ptr;

    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ARB_MODE == ARB_FIXED) begin
                idx = i;
            end else begin
                idx = (int'(ptr) + i) % NUM_REQ;
            end
            if (!grant_any && req[idx]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_en && grant_any) begin
            ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/bmem_arbiter.sv
// N-requester line-burst arbiter onto the shared bmem port: serialises line
// fills and writebacks, assembles read bursts and returns each line to its owner.
module bmem_arbiter
    import bmem_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BEAT_W    = DEF_BEAT_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int ARB_MODE  = ARB_RR,
    localparam int LINE_W   = line_width(BEAT_W, BURST_LEN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LINE_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [LINE_W-1:0]         resp_rdata,
    output logic [ADDR_W-1:0]         bmem_addr,
    output logic                      bmem_read,
    output logic                      bmem_write,
    output logic [BEAT_W-1:0]         bmem_wdata,
    input  logic                      bmem_ready,
    input  logic [ADDR_W-1:0]         bmem_raddr,
    input  logic [BEAT_W-1:0]         bmem_rdata,
    input  logic                      bmem_rvalid,
    output logic                      busy
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam int OWN_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_t        state, next_state;
    logic [OWN_W-1:0]  owner;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              grant_any;
    logic [OWN_W-1:0]  grant_idx;
    logic              grant_en;
    logic              beat_ok;
    logic              wr_acc;

    assign grant_en = (state == ST_IDLE);
    // Returning beats for other transactions share the bus; only our tag counts.
    assign beat_ok  = (state == ST_RD_DATA) && bmem_rvalid && (bmem_raddr == addr_q);
    assign wr_acc   = (state == ST_WR_BEAT) && bmem_ready;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .grant_en  (grant_en),
        .grant_any (grant_any),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        resp_valid = '0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    next_state = req_write[grant_idx] ? ST_WR_BEAT : ST_RD_REQ;
                end
            end
            ST_WR_BEAT: begin
                bmem_write = 1'b1;
                bmem_wdata = wdata_q[int'(cnt)*BEAT_W +: BEAT_W];
                if (bmem_ready && (cnt == LAST_BEAT)) begin
                    next_state = ST_RESP;
                end
            end
            ST_RD_REQ: begin
                bmem_read = 1'b1;
                if (bmem_ready) begin
                    next_state = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (beat_ok && (cnt == LAST_BEAT)) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid[owner] = 1'b1;
                next_state        = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign bmem_addr  = addr_q;
    assign resp_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= '0;
            addr_q  <= '0;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        owner  <= grant_idx;
                        addr_q <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                        cnt    <= '0;
                    end
                end
                ST_WR_BEAT: begin
                    if (wr_acc) begin
                        cnt <= (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (beat_ok) begin
                        rdata_q[int'(cnt)*BEAT_W +: BEAT_W] <= bmem_rdata;
                        cnt <= (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Writeback line is only consumed in WR_BEAT, so it needs no reset.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && grant_any) begin
            wdata_q <= req_wdata[int'(grant_idx)*LINE_W +: LINE_W];
        end
    end

endmodule
